op_centric_queue: RTL and testbench
===================================

# op_centric_queue

Single-clock FIFO queue with an operation-centric interface: one enable/ready pair for push-to-back and one for pop-from-front. It is used as a storage element between a producer and a consumer in the same clock domain. Each operation fires on a single rising clock edge when its enable and ready are both high. Popped data is registered and held until the next pop.

## Interface
- p_depth, default 32: number of entries (≥2; need not be a power of two).
- p_bitwidth, default 32: width of each data word.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- push_back_en  input  1  request to push push_back_data onto the back of the queue.
- push_back_rdy  output  1  high when the queue is not full.
- push_back_data  input  p_bitwidth  data word to push.
- pop_front_en  input  1  request to pop the front entry.
- pop_front_rdy  output  1  high when the queue is not empty.
- pop_front_data  output  p_bitwidth  registered copy of the most recently popped word.

## Operation
- State:
  - p_depth × p_bitwidth storage array.
  - Head pointer and tail pointer, each wrapping from p_depth−1 to 0.
  - Occupancy count, 0..p_depth.
- Push fires when push_back_en && push_back_rdy:
  - mem[tail] <= push_back_data.
  - tail advances with wrap.
- Pop fires when pop_front_en && pop_front_rdy:
  - pop_front_data <= mem[head].
  - head advances with wrap.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Both in the same cycle: unchanged.
- Readiness is derived from the registered count:
  - push_back_rdy = (count != p_depth).
  - pop_front_rdy = (count != 0).
- An enable presented while its ready is low is ignored. There is no state change and no error indication.
- Full queue with push and pop in the same cycle: only the pop fires. The push is dropped because push_back_rdy was low.
- Empty queue with push and pop in the same cycle: only the push fires. pop_front_data is unchanged.
- pop_front_data holds its value on every cycle without a fired pop.
- FIFO order is strict: words pop in exactly the order they were pushed, across any number of pointer wraps.
- Data is stored unmodified at full width.

## Timing
- Reset: rst low at a rising edge sets the following. Reset takes priority over any enable in that cycle.
  - count = 0, head = 0, tail = 0.
  - pop_front_data = 0.
  - push_back_rdy = 1, pop_front_rdy = 0.
- Storage contents need not be reset.
- Reset asserted mid-operation discards all queued entries.
- Push latency:
  - The pushed word is visible to pop starting the edge after it is written.
  - pop_front_rdy rises one cycle after the first push into an empty queue.
- Pop latency: pop_front_data is valid immediately after the rising edge on which the pop fires. It is valid at the following falling edge.
- Readiness outputs change only on the rising edge, so they are glitch-free with respect to input changes.
- Throughput: one push and one pop per cycle are sustainable.
- A held enable fires once per cycle while ready remains high.

## Test plan
- Reset, then idle → push_back_rdy=1, pop_front_rdy=0, pop_front_data=0.
- Push distinct random words until full, one per enable pulse:
  - push_back_rdy=1 throughout.
  - After push number p_depth (e.g. 8 for p_depth=8), push_back_rdy=0.
- From full, pop p_depth times:
  - Each pop_front_data equals the push-order word at the falling edge after the popping rising edge.
  - After the last pop, pop_front_rdy=0.
- Push and pop interleaved over 1..1000 random words with random gaps of 0–10 cycles, for (bitwidth, depth) = (8,8), (16,16) and (32,32):
  - Every popped word matches push order.
  - This exercises pointer wrap.
- Enables while not ready:
  - Push at full: queue contents unchanged, count stays p_depth.
  - Pop at empty: pop_front_data holds its prior value, pop_front_rdy stays 0.
- Edge cases:
  - Full with both enables asserted: one pop, and count drops to p_depth−1.
  - Empty with both enables asserted: one push, and count becomes 1.
  - rst=0 mid-stream: queue empties and pop_front_data=0.

Source files
------------

// File: rtl/op_centric_queue_if.sv
// Handshake bundle for op_centric_queue: a push-to-back port and a pop-from-front port.
// The queue takes the slave modport; the producer/consumer side takes the master modport.
interface op_centric_queue_if #(
    parameter int p_bitwidth = 32
);
    logic                  push_back_en;
    logic                  push_back_rdy;
    logic [p_bitwidth-1:0] push_back_data;
    logic                  pop_front_en;
    logic                  pop_front_rdy;
    logic [p_bitwidth-1:0] pop_front_data;

    modport master (
        output push_back_en, push_back_data, pop_front_en,
        input  push_back_rdy, pop_front_rdy, pop_front_data
    );

    modport slave (
        input  push_back_en, push_back_data, pop_front_en,
        output push_back_rdy, pop_front_rdy, pop_front_data
    );
endinterface

// File: rtl/op_centric_queue.sv
// Single-clock circular FIFO with separate push-back and pop-front enable/ready pairs.
// Readiness comes straight from the registered occupancy; popped data is registered and held.
module op_centric_queue #(
    parameter int p_depth    = 32,
    parameter int p_bitwidth = 32
) (
    input logic               clk,
    input logic               rst,
    op_centric_queue_if.slave q
);
    localparam int ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int cnt_w = $clog2(p_depth + 1);

    logic [p_bitwidth-1:0] mem [p_depth];
    logic [ptr_w-1:0]      head;
    logic [ptr_w-1:0]      tail;
    logic [cnt_w-1:0]      count;
    logic [p_bitwidth-1:0] pop_data_p1;
    logic                  push_fire;
    logic                  pop_fire;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(p_depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign q.push_back_rdy  = (count != cnt_w'(p_depth));
    assign q.pop_front_rdy  = (count != '0);
    assign push_fire        = q.push_back_en && q.push_back_rdy;
    assign pop_fire         = q.pop_front_en && q.pop_front_rdy;
    assign q.pop_front_data = pop_data_p1;

    // Storage is write-only from this block and carries no reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[tail] <= q.push_back_data;
        end
    end

    // Stage boundary: control state and the registered pop word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            pop_data_p1 <= '0;
        end else begin
            if (push_fire) begin
                tail <= next_ptr(tail);
            end
            if (pop_fire) begin
                head        <= next_ptr(head);
                pop_data_p1 <= mem[head];
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_op_centric_queue.sv
// Scoreboard bench for op_centric_queue over three (width, depth) configurations.
// A selector routes the generic stimulus signals to one instance at a time.
module tb_op_centric_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        push_en = 1'b0;
    logic        pop_en = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_rdy;
    logic        pop_rdy;
    logic [31:0] pop_data;

    op_centric_queue_if #(.p_bitwidth(8))  if8 ();
    op_centric_queue_if #(.p_bitwidth(16)) if16 ();
    op_centric_queue_if #(.p_bitwidth(32)) if32 ();

    op_centric_queue #(.p_depth(8),  .p_bitwidth(8))  dut8  (.clk(clk), .rst(rst), .q(if8));
    op_centric_queue #(.p_depth(16), .p_bitwidth(16)) dut16 (.clk(clk), .rst(rst), .q(if16));
    op_centric_queue #(.p_depth(32), .p_bitwidth(32)) dut32 (.clk(clk), .rst(rst), .q(if32));

    assign if8.push_back_en    = push_en && (sel == 0);
    assign if8.pop_front_en    = pop_en && (sel == 0);
    assign if8.push_back_data  = push_data[7:0];
    assign if16.push_back_en   = push_en && (sel == 1);
    assign if16.pop_front_en   = pop_en && (sel == 1);
    assign if16.push_back_data = push_data[15:0];
    assign if32.push_back_en   = push_en && (sel == 2);
    assign if32.pop_front_en   = pop_en && (sel == 2);
    assign if32.push_back_data = push_data;

    always_comb begin
        push_rdy = if8.push_back_rdy;
        pop_rdy  = if8.pop_front_rdy;
        pop_data = {24'b0, if8.pop_front_data};
        if (sel == 1) begin
            push_rdy = if16.push_back_rdy;
            pop_rdy  = if16.pop_front_rdy;
            pop_data = {16'b0, if16.pop_front_data};
        end else if (sel == 2) begin
            push_rdy = if32.push_back_rdy;
            pop_rdy  = if32.pop_front_rdy;
            pop_data = if32.pop_front_data;
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    int          mcount = 0;
    logic [31:0] last_pop = '0;

    function automatic int depth_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return (s == 0) ? 32'h0000_00ff : (s == 1) ? 32'h0000_ffff : 32'hffff_ffff;
    endfunction

    // Resets every instance and the reference model; returns just after a falling edge.
    task automatic apply_reset();
        push_en = 1'b0;
        pop_en  = 1'b0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        mcount   = 0;
        last_pop = '0;
    endtask

    // One clock of stimulus: the model decides what should fire, then outputs settle to the next falling edge.
    task automatic drive_cycle(input logic pe, input logic [31:0] pd, input logic qe,
                               output logic pushed, output logic popped, output logic [31:0] exp_word);
        pushed   = pe && (mcount != depth_of(sel));
        popped   = qe && (mcount != 0);
        exp_word = last_pop;
        if (popped) begin
            exp_word = sb.pop_front();
            last_pop = exp_word;
            mcount--;
        end
        if (pushed) begin
            sb.push_back(pd & mask_of(sel));
            mcount++;
        end
        push_en   = pe;
        push_data = pd;
        pop_en    = qe;
        @(posedge clk);
        @(negedge clk);
        push_en = 1'b0;
        pop_en  = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if (push_rdy !== 1'b1) begin bad++; $display("FAIL reset_push_rdy cfg%0d: got %b want 1", s, push_rdy); end
            total++;
            if (pop_rdy !== 1'b0) begin bad++; $display("FAIL reset_pop_rdy cfg%0d: got %b want 0", s, pop_rdy); end
            total++;
            if (pop_data !== 32'h0) begin bad++; $display("FAIL reset_pop_data cfg%0d: got %h want 0", s, pop_data); end
        end
        sel = 0;
    endtask

    task automatic test_fill();
        logic        pu, po;
        logic [31:0] ex;
        logic [31:0] base;
        base = $urandom;
        for (int i = 0; i < depth_of(sel); i++) begin
            total++;
            if (push_rdy !== 1'b1) begin bad++; $display("FAIL fill_push_rdy[%0d]: got %b want 1", i, push_rdy); end
            drive_cycle(1'b1, base + 32'(i), 1'b0, pu, po, ex);
            if (i == 0) begin
                total++;
                if (pop_rdy !== 1'b1) begin bad++; $display("FAIL first_push_pop_rdy: got %b want 1", pop_rdy); end
            end
        end
        total++;
        if (push_rdy !== 1'b0) begin bad++; $display("FAIL full_push_rdy: got %b want 0", push_rdy); end
    endtask

    task automatic test_full_push_ignored();
        logic        pu, po;
        logic [31:0] ex;
        drive_cycle(1'b1, 32'hdead_beef, 1'b0, pu, po, ex);
        total++;
        if (push_rdy !== 1'b0) begin bad++; $display("FAIL full_push_ignored_rdy: got %b want 0", push_rdy); end
        total++;
        if (pop_data !== last_pop) begin bad++; $display("FAIL full_push_ignored_data: got %h want %h", pop_data, last_pop); end
    endtask

    task automatic test_drain();
        logic        pu, po;
        logic [31:0] ex;
        int          n;
        n = mcount;
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1, pu, po, ex);
            total++;
            if (pop_data !== ex) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, pop_data, ex); end
        end
        total++;
        if (pop_rdy !== 1'b0) begin bad++; $display("FAIL drain_pop_rdy: got %b want 0", pop_rdy); end
        total++;
        if (push_rdy !== 1'b1) begin bad++; $display("FAIL drain_push_rdy: got %b want 1", push_rdy); end
    endtask

    task automatic test_empty_pop();
        logic        pu, po;
        logic [31:0] ex;
        drive_cycle(1'b0, 32'h0, 1'b1, pu, po, ex);
        total++;
        if (pop_data !== last_pop) begin bad++; $display("FAIL empty_pop_hold: got %h want %h", pop_data, last_pop); end
        total++;
        if (pop_rdy !== 1'b0) begin bad++; $display("FAIL empty_pop_rdy: got %b want 0", pop_rdy); end
    endtask

    task automatic test_empty_both();
        logic        pu, po;
        logic [31:0] ex, w;
        w = ($urandom & mask_of(sel)) ^ last_pop ^ 32'h1;
        drive_cycle(1'b1, w, 1'b1, pu, po, ex);
        total++;
        if (pop_data !== last_pop) begin bad++; $display("FAIL empty_both_hold: got %h want %h", pop_data, last_pop); end
        total++;
        if (pop_rdy !== 1'b1) begin bad++; $display("FAIL empty_both_pop_rdy: got %b want 1", pop_rdy); end
        drive_cycle(1'b0, 32'h0, 1'b1, pu, po, ex);
        total++;
        if (pop_data !== ex) begin bad++; $display("FAIL empty_both_word: got %h want %h", pop_data, ex); end
        total++;
        if (pop_rdy !== 1'b0) begin bad++; $display("FAIL empty_both_count1: got pop_rdy %b want 0", pop_rdy); end
    endtask

    task automatic test_full_both();
        logic        pu, po;
        logic [31:0] ex;
        for (int i = 0; i < depth_of(sel); i++) begin
            drive_cycle(1'b1, $urandom, 1'b0, pu, po, ex);
        end
        drive_cycle(1'b1, 32'h5a5a_5a5a, 1'b1, pu, po, ex);
        total++;
        if (pop_data !== ex) begin bad++; $display("FAIL full_both_data: got %h want %h", pop_data, ex); end
        total++;
        if (push_rdy !== 1'b1) begin bad++; $display("FAIL full_both_push_rdy: got %b want 1", push_rdy); end
        test_drain();
    endtask

    task automatic test_back_to_back();
        logic        pu, po;
        logic [31:0] ex;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, $urandom, 1'b0, pu, po, ex);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, $urandom, 1'b1, pu, po, ex);
            total++;
            if (pop_data !== ex) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, pop_data, ex); end
            total++;
            if ((push_rdy !== 1'b1) || (pop_rdy !== 1'b1)) begin
                bad++; $display("FAIL b2b_rdy[%0d]: got %b%b want 11", i, push_rdy, pop_rdy);
            end
        end
        test_drain();
    endtask

    task automatic test_mid_reset();
        logic        pu, po;
        logic [31:0] ex;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, $urandom | 32'h1, 1'b0, pu, po, ex);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, pu, po, ex);
        // Enables held high while reset is low: reset must win.
        rst       = 1'b0;
        push_en   = 1'b1;
        pop_en    = 1'b1;
        push_data = 32'h1234_5677;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        sb.delete();
        mcount   = 0;
        last_pop = '0;
        total++;
        if (pop_data !== 32'h0) begin bad++; $display("FAIL mid_reset_data: got %h want 0", pop_data); end
        total++;
        if (pop_rdy !== 1'b0) begin bad++; $display("FAIL mid_reset_pop_rdy: got %b want 0", pop_rdy); end
        total++;
        if (push_rdy !== 1'b1) begin bad++; $display("FAIL mid_reset_push_rdy: got %b want 1", push_rdy); end
        drive_cycle(1'b1, 32'h0000_00a5, 1'b0, pu, po, ex);
        drive_cycle(1'b0, 32'h0, 1'b1, pu, po, ex);
        total++;
        if (pop_data !== ex) begin bad++; $display("FAIL post_reset_word: got %h want %h", pop_data, ex); end
    endtask

    task automatic test_interleave(input int s);
        logic        pu, po, pe, qe;
        logic [31:0] ex;
        int          n, pushed_n, popped_n, pgap, qgap, cyc;
        sel = s;
        apply_reset();
        n = $urandom_range(1, 1000);
        pushed_n = 0;
        popped_n = 0;
        pgap = $urandom_range(0, 10);
        qgap = $urandom_range(0, 10);
        cyc = 0;
        while ((popped_n < n) && (cyc < 15000)) begin
            pe = (pushed_n < n) && (pgap == 0);
            qe = (qgap == 0);
            drive_cycle(pe, $urandom, qe, pu, po, ex);
            if (pu) begin pushed_n++; pgap = $urandom_range(0, 10); end
            else if (pgap > 0) pgap--;
            if (po) begin
                popped_n++;
                qgap = $urandom_range(0, 10);
                total++;
                if (pop_data !== ex) begin bad++; $display("FAIL interleave cfg%0d word %0d: got %h want %h", s, popped_n, pop_data, ex); end
            end else if (qgap > 0) qgap--;
            total++;
            if (pop_rdy !== (mcount != 0)) begin bad++; $display("FAIL interleave cfg%0d pop_rdy cyc %0d: got %b want %b", s, cyc, pop_rdy, mcount != 0); end
            cyc++;
        end
        total++;
        if (popped_n != n) begin bad++; $display("FAIL interleave cfg%0d timeout: popped %0d want %0d", s, popped_n, n); end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_fill();
        test_full_push_ignored();
        test_drain();
        test_empty_pop();
        test_empty_both();
        test_full_both();
        test_back_to_back();
        test_mid_reset();
        test_interleave(0);
        test_interleave(1);
        test_interleave(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
